// File: rtl/requantize_control.sv
// Requantize sequencer: walks lines 0..N-1 of a granule, derives band/window/mode
// per line from the 44.1 kHz band tables, and handshakes each line with the calc block.
module requantize_control (
  input  logic       clk,
  input  logic       rst,
  input  logic       go_i,
  input  logic [1:0] block_type_i,
  input  logic       mixed_block_flag_i,
  input  logic [9:0] nonzero_count_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       calc_start_o,
  input  logic       calc_ready_i,
  input  logic       calc_active_i,
  output logic [9:0] calc_index_o,
  output logic [4:0] calc_cb_o,
  output logic [1:0] calc_window_o,
  output logic       calc_calc_mode_o
);

  localparam logic [9:0] LINES      = 10'd576;
  localparam logic [9:0] MIXED_LAST = 10'd35;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef struct packed {
    logic [9:0] idx;
    logic [4:0] cb;
    logic [1:0] win;
    logic       mode;
    logic [7:0] pos;
  } line_t;

  localparam line_t LINE_RST = '{idx: 10'd0, cb: 5'd0, win: 2'd0, mode: 1'b1, pos: 8'd0};

  function automatic logic [7:0] long_width(input logic [4:0] cb);
    case (cb)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5: long_width = 8'd4;
      5'd6, 5'd7:                         long_width = 8'd6;
      5'd8, 5'd9:                         long_width = 8'd8;
      5'd10:                              long_width = 8'd10;
      5'd11:                              long_width = 8'd12;
      5'd12:                              long_width = 8'd16;
      5'd13:                              long_width = 8'd20;
      5'd14:                              long_width = 8'd24;
      5'd15:                              long_width = 8'd28;
      5'd16:                              long_width = 8'd34;
      5'd17:                              long_width = 8'd42;
      5'd18:                              long_width = 8'd50;
      5'd19:                              long_width = 8'd54;
      5'd20:                              long_width = 8'd76;
      default:                            long_width = 8'd158;
    endcase
  endfunction

  function automatic logic [7:0] short_width(input logic [4:0] cb);
    case (cb)
      5'd0, 5'd1, 5'd2, 5'd3: short_width = 8'd4;
      5'd4:                   short_width = 8'd6;
      5'd5:                   short_width = 8'd8;
      5'd6:                   short_width = 8'd10;
      5'd7:                   short_width = 8'd12;
      5'd8:                   short_width = 8'd14;
      5'd9:                   short_width = 8'd18;
      5'd10:                  short_width = 8'd22;
      5'd11:                  short_width = 8'd30;
      default:                short_width = 8'd56;
    endcase
  endfunction

  state_t     state_q;
  line_t      line_q, line_d;
  logic [9:0] n_q, n_go;
  logic       mixed_q, busy_q, done_q, start_q;
  logic [7:0] width;
  logic       last, complete;

  always_comb begin
    width    = line_q.mode ? long_width(line_q.cb) : short_width(line_q.cb);
    line_d   = line_q;
    line_d.idx = line_q.idx + 10'd1;
    // Mixed blocks hand over from long band 7 to short band 3 at line 36.
    if (mixed_q && line_q.mode && line_q.idx == MIXED_LAST) begin
      line_d.mode = 1'b0;
      line_d.cb   = 5'd3;
      line_d.win  = 2'd0;
      line_d.pos  = 8'd0;
    end else if (line_q.pos == width - 8'd1) begin
      line_d.pos = 8'd0;
      if (line_q.mode || line_q.win == 2'd2) begin
        line_d.win = 2'd0;
        line_d.cb  = line_q.cb + 5'd1;
      end else begin
        line_d.win = line_q.win + 2'd1;
      end
    end else begin
      line_d.pos = line_q.pos + 8'd1;
    end
    last     = (line_d.idx == n_q);
    complete = calc_ready_i && calc_active_i && !start_q;
    n_go     = (nonzero_count_i > LINES) ? LINES : nonzero_count_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      line_q  <= LINE_RST;
      n_q     <= 10'd0;
      mixed_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_i) begin
            n_q         <= n_go;
            mixed_q     <= (block_type_i == 2'd2) && mixed_block_flag_i;
            line_q      <= LINE_RST;
            line_q.mode <= !((block_type_i == 2'd2) && !mixed_block_flag_i);
            if (n_go == 10'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
              start_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          // The tuple only moves on the calc block's final cycle, so it stays
          // stable for the block's combinational reads and its index latch.
          if (complete) begin
            if (last) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ISSUE;
              start_q <= 1'b1;
              line_q  <= line_d;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign calc_start_o     = start_q;
  assign calc_index_o     = line_q.idx;
  assign calc_cb_o        = line_q.cb;
  assign calc_window_o    = line_q.win;
  assign calc_calc_mode_o = line_q.mode;

endmodule

// File: tb/tb_requantize_control.sv
// Bench for requantize_control: table of granule runs against a line-tuple scoreboard,
// spot checks of band boundaries, plus reset and stray-go sequences.
module tb_requantize_control;

  logic       clk = 1'b0;
  logic       rst, go, mixed;
  logic [1:0] bt;
  logic [9:0] nz;
  logic       busy, done, calc_start, calc_ready, calc_active, mode;
  logic [9:0] idx;
  logic [4:0] cb;
  logic [1:0] win;

  requantize_control dut (
    .clk(clk), .rst(rst), .go_i(go), .block_type_i(bt), .mixed_block_flag_i(mixed),
    .nonzero_count_i(nz), .busy_o(busy), .done_o(done), .calc_start_o(calc_start),
    .calc_ready_i(calc_ready), .calc_active_i(calc_active), .calc_index_o(idx),
    .calc_cb_o(cb), .calc_window_o(win), .calc_calc_mode_o(mode)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; int cb; int win; int mode; int rel;} exp_t;
  typedef struct {int bt; int mx; int nz; int extra; int issued; int done_rel; int spur;} vec_t;
  typedef struct {int cs; int idx; int cb; int win; int mode;} spot_t;

  int    total = 0, bad = 0;
  int    cyc = 0, g = 0, extra = 0, cnt = 0;
  int    issued = 0, done_cnt = 0, done_rel = -1, last_tup = 0;
  bit    running = 0;
  int    lw[22], sw[13], cap[576];
  exp_t  sbq[$];
  exp_t  e;
  vec_t  vecs[7];
  spot_t spots[$];

  always @(posedge clk) cyc++;

  // Calculation block stand-in: active after start, final (ready) cycle at start+4+extra.
  always @(posedge clk) begin
    if (rst) cnt <= 0;
    else if (calc_start) cnt <= 1;
    else if (cnt != 0) cnt <= (cnt == 4 + extra) ? 0 : cnt + 1;
  end
  assign calc_active = (cnt != 0);
  assign calc_ready  = (cnt == 4 + extra);

  function automatic int tup(input int i, input int c, input int w, input int m);
    return i * 256 + c * 8 + w * 2 + m;
  endfunction

  task automatic chk(input string nm, input bit ok, input int act, input int exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && running) begin
      if (calc_start) begin
        issued++;
        last_tup = tup(idx, cb, win, mode);
        if (idx < 576) cap[idx] = last_tup;
        if (sbq.size() == 0) chk("extra_start", 1'b0, last_tup, -1);
        else begin
          e = sbq.pop_front();
          chk("tuple", last_tup == tup(e.idx, e.cb, e.win, e.mode), last_tup,
              tup(e.idx, e.cb, e.win, e.mode));
          chk("start_cycle", cyc - g == e.rel, cyc - g, e.rel);
          chk("busy_at_start", busy == 1'b1, busy, 1);
        end
      end
      if (calc_ready && calc_active)
        chk("tuple_hold", tup(idx, cb, win, mode) == last_tup, tup(idx, cb, win, mode), last_tup);
      if (done) begin
        done_cnt++;
        done_rel = cyc - g;
        chk("busy_at_done", busy == 1'b0, busy, 0);
      end
    end
  end

  task automatic push_line(input int k, input int c, input int w, input int m,
                           input int n, input int ex);
    exp_t x;
    if (k < n) begin
      x.idx = k; x.cb = c; x.win = w; x.mode = m; x.rel = 1 + (5 + ex) * k;
      sbq.push_back(x);
    end
  endtask

  task automatic push_expected(input int btp, input int mx, input int n, input int ex);
    int k;
    k = 0;
    if (btp != 2 || mx != 0)
      for (int c = 0; c <= ((btp != 2) ? 21 : 7); c++)
        for (int j = 0; j < lw[c]; j++) begin push_line(k, c, 0, 1, n, ex); k++; end
    if (btp == 2)
      for (int c = (mx != 0) ? 3 : 0; c <= 12; c++)
        for (int w = 0; w < 3; w++)
          for (int j = 0; j < sw[c]; j++) begin push_line(k, c, w, 0, n, ex); k++; end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy == 1'b0, busy, 0);
    chk({tag, "_done"}, done == 1'b0, done, 0);
    chk({tag, "_start"}, calc_start == 1'b0, calc_start, 0);
    chk({tag, "_tuple"}, tup(idx, cb, win, mode) == tup(0, 0, 0, 1), tup(idx, cb, win, mode),
        tup(0, 0, 0, 1));
  endtask

  task automatic run_granule(input int ci);
    vec_t v;
    bit   to;
    v = vecs[ci];
    extra = v.extra; sbq.delete(); issued = 0; done_cnt = 0; done_rel = -1;
    foreach (cap[i]) cap[i] = -1;
    push_expected(v.bt, v.mx, v.issued, v.extra);
    @(posedge clk); #1;
    go = 1'b1; bt = v.bt[1:0]; mixed = v.mx[0]; nz = v.nz[9:0]; g = cyc; running = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) begin to = 1'b0; break; end
      if (cyc - g == v.spur) begin go = 1'b1; bt = 2'd2; mixed = 1'b0; nz = 10'd3; end
      else go = 1'b0;
    end
    go = 1'b0;
    if (to) chk("done_timeout", 1'b0, cyc - g, v.done_rel);
    repeat (8) @(negedge clk);
    chk("idle_after", busy == 1'b0, busy, 0);
    chk("done_pulses", done_cnt == 1, done_cnt, 1);
    chk("done_cycle", done_rel == v.done_rel, done_rel, v.done_rel);
    chk("issued", issued == v.issued, issued, v.issued);
    chk("sb_empty", sbq.size() == 0, sbq.size(), 0);
    foreach (spots[i])
      if (spots[i].cs == ci)
        chk("spot", cap[spots[i].idx] == tup(spots[i].idx, spots[i].cb, spots[i].win, spots[i].mode),
            cap[spots[i].idx], tup(spots[i].idx, spots[i].cb, spots[i].win, spots[i].mode));
  endtask

  initial begin
    lw = '{4, 4, 4, 4, 4, 4, 6, 6, 8, 8, 10, 12, 16, 20, 24, 28, 34, 42, 50, 54, 76, 158};
    sw = '{4, 4, 4, 4, 6, 8, 10, 12, 14, 18, 22, 30, 56};
    //          bt mx  nz  ex iss  done  spur
    vecs[0] = '{0, 0, 10,  0, 10,  51,   12};
    vecs[1] = '{2, 0, 576, 0, 576, 2881, -1};
    vecs[2] = '{2, 1, 576, 0, 576, 2881, -1};
    vecs[3] = '{1, 0, 700, 0, 576, 2881, -1};
    vecs[4] = '{0, 0, 0,   0, 0,   1,    -1};
    vecs[5] = '{3, 1, 7,   2, 7,   50,   -1};
    vecs[6] = '{2, 1, 40,  0, 40,  201,  201};
    spots.push_back('{0, 0, 0, 0, 1});   spots.push_back('{0, 4, 1, 0, 1});
    spots.push_back('{0, 9, 2, 0, 1});   spots.push_back('{1, 3, 0, 0, 0});
    spots.push_back('{1, 4, 0, 1, 0});   spots.push_back('{1, 8, 0, 2, 0});
    spots.push_back('{1, 12, 1, 0, 0});  spots.push_back('{1, 48, 4, 0, 0});
    spots.push_back('{1, 54, 4, 1, 0});  spots.push_back('{1, 575, 12, 2, 0});
    spots.push_back('{2, 35, 7, 0, 1});  spots.push_back('{2, 36, 3, 0, 0});
    spots.push_back('{2, 40, 3, 1, 0});  spots.push_back('{2, 48, 4, 0, 0});
    spots.push_back('{3, 417, 20, 0, 1}); spots.push_back('{3, 418, 21, 0, 1});
    spots.push_back('{3, 575, 21, 0, 1}); spots.push_back('{6, 39, 3, 0, 0});

    rst = 1'b1; go = 1'b0; bt = 2'd0; mixed = 1'b0; nz = 10'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 7; i++) run_granule(i);

    // Reset in the middle of a long N=10 granule: no done, then a clean restart.
    extra = 0; sbq.delete(); issued = 0; done_cnt = 0;
    push_expected(0, 0, 10, 0);
    @(posedge clk); #1;
    go = 1'b1; bt = 2'd0; mixed = 1'b0; nz = 10'd10; g = cyc;
    while (cyc - g < 23) begin @(posedge clk); #1; go = 1'b0; end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_cycle", cyc - g == 24, cyc - g, 24);
    chk_reset_vals("midrst");
    rst = 1'b0;
    chk("issued_before_rst", issued == 5, issued, 5);
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("no_done_after_rst", done_cnt == 0, done_cnt, 0);
    chk("idle_after_rst", busy == 1'b0, busy, 0);
    run_granule(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
